mux_operand_pipe: RTL and testbench

- Parametrised successor to the fixed 4:1 ALU operand selector.
- Selects one of NUM_INPUTS WIDTH-bit operands and registers the chosen word.
- Delivers the word through a valid/ready handshake with a 2-entry skid buffer, so the datapath can stall the ALU operand without losing or duplicating data.
- Flags and counts out-of-range selector codes.

---
 rtl/mux_operand_pipe.sv | 129 ++++++++++++
 tb/tb_mux_operand_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_operand_pipe.sv
// Parametrised ALU operand selector: picks one of NUM_INPUTS words, flags bad
// selector codes and hands the result downstream through a 2-entry skid buffer.
`timescale 1ns/1ps
module mux_operand_pipe #(
    parameter int WIDTH         = 32,
    parameter int NUM_INPUTS    = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEL_WIDTH-1:0]        selector,
    input  logic [NUM_INPUTS*WIDTH-1:0] input_bus,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            output_final,
    output logic                        sel_error,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ERR_CNT_WIDTH-1:0]    err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [WIDTH-1:0]         head_data_q, head_data_d;
    logic                     head_err_q, head_err_d;
    logic [WIDTH-1:0]         skid_data_q, skid_data_d;
    logic                     skid_err_q, skid_err_d;
    logic                     in_ready_q, in_ready_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]         sel_data;
    logic                     sel_err;
    logic                     in_fire;
    logic                     out_fire;

    // Out-of-range codes fall back to operand 0 and raise the error flag.
    always_comb begin
        sel_data = input_bus[WIDTH-1:0];
        sel_err  = 1'b1;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            if (selector == SEL_WIDTH'(k)) begin
                sel_data = input_bus[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    head_data_d = sel_data;
                    head_err_d  = sel_err;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_data_d = sel_data;
                    head_err_d  = sel_err;
                end else if (in_fire) begin
                    state_d     = TWO;
                    skid_data_d = sel_data;
                    skid_err_d  = sel_err;
                end else if (out_fire) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d     = ONE;
                    head_data_d = skid_data_q;
                    head_err_d  = skid_err_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (in_fire && sel_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end

        // Ready is registered, so it must look ahead at the state being entered.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign output_final = head_data_q;
    assign sel_error    = head_err_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_mux_operand_pipe.sv
// Bench for mux_operand_pipe: two instances (4 operands / 8-bit counter and
// 3 operands / 2-bit counter) checked against a queue-based FIFO model.
`timescale 1ns/1ps
module tb_mux_operand_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_error;
    logic [1:0]   a_sel;
    logic [127:0] a_bus;
    logic [31:0]  a_out;
    logic [7:0]   a_cnt;

    logic         b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_error;
    logic [1:0]   b_sel;
    logic [95:0]  b_bus;
    logic [31:0]  b_out;
    logic [1:0]   b_cnt;

    mux_operand_pipe #(.WIDTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .ERR_CNT_WIDTH(8)) u_a (
        .clk(clk), .reset(a_rst_n), .selector(a_sel), .input_bus(a_bus),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .output_final(a_out),
        .sel_error(a_sel_error), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .err_count(a_cnt)
    );

    mux_operand_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2), .ERR_CNT_WIDTH(2)) u_b (
        .clk(clk), .reset(b_rst_n), .selector(b_sel), .input_bus(b_bus),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .output_final(b_out),
        .sel_error(b_sel_error), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_count(b_cnt)
    );

    int checks = 0;
    int fails  = 0;

    // Model: queue of {err, data}; ready = armed and fewer than two entries held.
    logic [32:0] qa[$];
    logic [32:0] qb[$];
    bit          armed_a, armed_b;
    int          cnt_a, cnt_b;

    function automatic logic [32:0] pick(input logic [127:0] bus, input logic [1:0] sel, input int n);
        if (int'(sel) < n) return {1'b0, bus[int'(sel)*32 +: 32]};
        return {1'b1, bus[31:0]};
    endfunction

    task automatic step_a();
        bit inf, outf;
        logic [32:0] w;
        inf  = a_rst_n && a_in_valid && armed_a && (qa.size() < 2);
        outf = a_rst_n && a_out_ready && (qa.size() > 0);
        w    = pick(a_bus, a_sel, 4);
        @(posedge clk); #1;
        if (!a_rst_n) return;
        if (outf) void'(qa.pop_front());
        if (inf) begin
            qa.push_back(w);
            if (w[32] && cnt_a < 255) cnt_a++;
        end
        armed_a = 1;
    endtask

    task automatic step_b();
        bit inf, outf;
        logic [32:0] w;
        inf  = b_rst_n && b_in_valid && armed_b && (qb.size() < 2);
        outf = b_rst_n && b_out_ready && (qb.size() > 0);
        w    = pick({32'h0, b_bus}, b_sel, 3);
        @(posedge clk); #1;
        if (!b_rst_n) return;
        if (outf) void'(qb.pop_front());
        if (inf) begin
            qb.push_back(w);
            if (w[32] && cnt_b < 3) cnt_b++;
        end
        armed_b = 1;
    endtask

    task automatic assert_reset_a();
        a_rst_n = 0; qa.delete(); armed_a = 0; cnt_a = 0;
    endtask

    task automatic restart_b();
        b_rst_n = 0; qb.delete(); armed_b = 0; cnt_b = 0;
        @(posedge clk); #1;
        b_rst_n = 1;
    endtask

    task automatic test_reset();
        a_bus = {32'h44, 32'h33, 32'h22, 32'h11};
        a_sel = 2'd2; a_in_valid = 1; a_out_ready = 1;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0 || a_out !== 32'h0 || a_in_ready !== 1'b0 || a_cnt !== 8'h0) begin
            fails++; $display("FAIL reset_state: valid=%b out=%h ready=%b cnt=%h, required 0/0/0/0", a_out_valid, a_out, a_in_ready, a_cnt);
        end
        a_rst_n = 1;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin
            fails++; $display("FAIL ready_at_release: got %b required 0", a_in_ready);
        end
        step_a();
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            fails++; $display("FAIL ready_first_edge: ready=%b valid=%b required 1/0", a_in_ready, a_out_valid);
        end
        step_a();
        checks++; if (a_out_valid !== 1'b1 || a_out !== 32'h33 || a_sel_error !== 1'b0) begin
            fails++; $display("FAIL first_word: valid=%b out=%h err=%b required 1/00000033/0", a_out_valid, a_out, a_sel_error);
        end
        a_in_valid = 0;
        step_a();
        checks++; if (a_out_valid !== 1'b0) begin
            fails++; $display("FAIL drain_after_first: valid=%b required 0", a_out_valid);
        end
    endtask

    task automatic test_skid();
        a_out_ready = 0; a_sel = 2'd0; a_in_valid = 1;
        a_bus = {96'h0, 32'h1};
        step_a();
        a_bus = {96'h0, 32'h2};
        step_a();
        a_in_valid = 0;
        checks++; if (a_out_valid !== 1'b1 || a_out !== 32'h1 || a_in_ready !== 1'b0) begin
            fails++; $display("FAIL skid_full: valid=%b out=%h ready=%b required 1/00000001/0", a_out_valid, a_out, a_in_ready);
        end
        step_a();
        checks++; if (a_out !== 32'h1 || a_in_ready !== 1'b0) begin
            fails++; $display("FAIL skid_hold: out=%h ready=%b required 00000001/0", a_out, a_in_ready);
        end
        a_out_ready = 1;
        step_a();
        checks++; if (a_out_valid !== 1'b1 || a_out !== 32'h2 || a_in_ready !== 1'b1) begin
            fails++; $display("FAIL skid_second: valid=%b out=%h ready=%b required 1/00000002/1", a_out_valid, a_out, a_in_ready);
        end
        step_a();
        checks++; if (a_out_valid !== 1'b0) begin
            fails++; $display("FAIL skid_empty: valid=%b required 0", a_out_valid);
        end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 0; a_sel = 2'd0; a_in_valid = 1;
        a_bus = {96'h0, 32'h5};
        step_a();
        a_bus = {96'h0, 32'h6};
        step_a();
        a_in_valid = 0;
        checks++; if (a_in_ready !== 1'b0 || a_out !== 32'h5) begin
            fails++; $display("FAIL mid_two_before_reset: ready=%b out=%h required 0/00000005", a_in_ready, a_out);
        end
        assert_reset_a();
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_out !== 32'h0 || a_cnt !== 8'h0 || a_in_ready !== 1'b0 || a_sel_error !== 1'b0) begin
            fails++; $display("FAIL mid_reset: valid=%b out=%h cnt=%h ready=%b err=%b required all 0", a_out_valid, a_out, a_cnt, a_in_ready, a_sel_error);
        end
        @(posedge clk); #1;
        a_rst_n = 1;
        a_bus = {96'h0, 32'h7}; a_in_valid = 1;
        step_a();
        step_a();
        a_in_valid = 0;
        checks++; if (a_out_valid !== 1'b1 || a_out !== 32'h7) begin
            fails++; $display("FAIL post_reset_word: valid=%b out=%h required 1/00000007", a_out_valid, a_out);
        end
        a_out_ready = 1;
        step_a();
        checks++; if (a_out_valid !== 1'b0) begin
            fails++; $display("FAIL post_reset_stale: valid=%b out=%h required valid 0", a_out_valid, a_out);
        end
    endtask

    task automatic test_sel_error();
        b_bus = {32'hC0, 32'hB0, 32'hA0};
        b_sel = 2'd3; b_in_valid = 1; b_out_ready = 1;
        restart_b();
        step_b();
        step_b();
        checks++; if (b_out_valid !== 1'b1 || b_out !== 32'hA0 || b_sel_error !== 1'b1 || b_cnt !== 2'd1) begin
            fails++; $display("FAIL sel_out_of_range: valid=%b out=%h err=%b cnt=%0d required 1/000000a0/1/1", b_out_valid, b_out, b_sel_error, b_cnt);
        end
        b_sel = 2'd1;
        step_b();
        checks++; if (b_out_valid !== 1'b1 || b_out !== 32'hB0 || b_sel_error !== 1'b0 || b_cnt !== 2'd1) begin
            fails++; $display("FAIL sel_in_range: valid=%b out=%h err=%b cnt=%0d required 1/000000b0/0/1", b_out_valid, b_out, b_sel_error, b_cnt);
        end
        b_in_valid = 0;
        step_b();
    endtask

    task automatic test_saturation();
        int exp_sat[5] = '{1, 2, 3, 3, 3};
        b_in_valid = 0; b_out_ready = 1;
        restart_b();
        step_b();
        b_sel = 2'd3; b_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step_b();
            checks++; if (b_cnt !== 2'(exp_sat[i])) begin
                fails++; $display("FAIL err_sat[%0d]: got %0d required %0d", i, b_cnt, exp_sat[i]);
            end
        end
        b_in_valid = 0;
        step_b();
    endtask

    task automatic test_random();
        int popped = 0;
        int cyc    = 0;
        b_in_valid = 0; b_out_ready = 0;
        restart_b();
        while (popped < 1000 && cyc < 20000) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_sel       = 2'($urandom);
            b_bus       = {$urandom, $urandom, $urandom};
            if (b_out_ready && qb.size() > 0) popped++;
            step_b();
            cyc++;
            checks++; if (b_out_valid !== (qb.size() > 0)) begin
                fails++; $display("FAIL rnd_valid@%0d: got %b required %b", cyc, b_out_valid, qb.size() > 0);
            end
            checks++; if (b_in_ready !== (armed_b && qb.size() < 2)) begin
                fails++; $display("FAIL rnd_ready@%0d: got %b required %b", cyc, b_in_ready, armed_b && qb.size() < 2);
            end
            checks++; if (b_cnt !== 2'(cnt_b)) begin
                fails++; $display("FAIL rnd_cnt@%0d: got %0d required %0d", cyc, b_cnt, cnt_b);
            end
            if (qb.size() > 0) begin
                checks++; if ({b_sel_error, b_out} !== qb[0]) begin
                    fails++; $display("FAIL rnd_head@%0d: got err=%b data=%h required err=%b data=%h", cyc, b_sel_error, b_out, qb[0][32], qb[0][31:0]);
                end
            end
        end
        checks++; if (popped < 1000) begin
            fails++; $display("FAIL rnd_budget: delivered %0d words, required 1000", popped);
        end
        b_in_valid = 0;
    endtask

    initial begin
        a_rst_n = 0; b_rst_n = 0;
        a_in_valid = 0; a_out_ready = 0; a_sel = '0; a_bus = '0;
        b_in_valid = 0; b_out_ready = 0; b_sel = '0; b_bus = '0;
        armed_a = 0; armed_b = 0; cnt_a = 0; cnt_b = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_skid();
        test_reset_mid();
        test_sel_error();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
